i2c_sensor_seq_cfg: RTL and testbench
=====================================

I2C_SENSOR_SEQ_CFG -- requirements
Module: i2c_sensor_seq_cfg

Interface
REQ-001 SHALL have parameter REG_NUM, default 70, number of configuration table entries (1..1023).
REQ-002 SHALL have parameter ADDR16, default 0, where 0 means 8-bit sensor register address and 1 means 16-bit.
REQ-003 SHALL have parameter PWR_WAIT, default 1023, clk cycles from reset release or restart to the first transfer.
REQ-004 SHALL have parameter DLY_UNIT, default 1000, clk cycles per DELAY-command unit.
REQ-005 SHALL have parameter MAX_RETRY, default 3, re-issues allowed per entry after a NACK.
REQ-006 clk  in  1  sole clock; all logic on posedge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 restart  in  1  single-cycle pulse that re-runs the whole table.
REQ-009 i2c_done  in  1  single-cycle pulse from the I2C master marking the end of a transfer.
REQ-010 i2c_nack  in  1  slave NACK flag; valid only in the cycle where i2c_done=1.
REQ-011 i2c_exec  out  1  single-cycle transfer request to the I2C master.
REQ-012 i2c_addr  out  16  sensor register address; bits [15:8] are 0 when ADDR16=0.
REQ-013 i2c_data  out  8  write data.
REQ-014 i2c_bit_ctrl  out  1  equals ADDR16; tells the master how many address bytes to send.
REQ-015 cfg_idx  out  10  index of the current table entry.
REQ-016 init_done  out  1  sequence completed without error.
REQ-017 init_err  out  1  an entry exhausted its retries.

Function
REQ-018 Table entries SHALL be 26 bits: {cmd[1:0], addr[15:0], data[7:0]}, with cmd values WR=0, DLY=1, END=2.
REQ-019 The FSM SHALL have states PWRW, FETCH, ISSUE, WAIT, DELAY, DONE, ERR.
REQ-020 PWRW SHALL count PWR_WAIT cycles, then go to FETCH with cfg_idx=0 and the retry count cleared.
REQ-021 FETCH SHALL take 1 cycle (registered ROM read) and then decode the entry:
- WR goes to ISSUE.
- DLY goes to DELAY.
- END, or cfg_idx==REG_NUM, goes to DONE.
REQ-022 ISSUE SHALL load i2c_addr/i2c_data and assert i2c_exec for exactly 1 cycle, with outputs stable from that cycle until i2c_done; the state then goes to WAIT.
REQ-023 In WAIT, on i2c_done with i2c_nack=0: cfg_idx SHALL increment, the retry count SHALL clear, and the state SHALL go to FETCH.
REQ-024 In WAIT, on i2c_done with i2c_nack=1 and retry<MAX_RETRY: the retry count SHALL increment and the state SHALL return to ISSUE for the same entry.
REQ-025 In WAIT, on i2c_done with i2c_nack=1 and retry==MAX_RETRY: the state SHALL go to ERR.
REQ-026 DELAY SHALL wait data*DLY_UNIT cycles, where data=0 means 0 cycles, then cfg_idx+1 and FETCH; no i2c_exec is issued.
REQ-027 DONE SHALL set init_done=1 and hold it. ERR SHALL set init_err=1, hold cfg_idx at the failing entry, and hold it.
REQ-028 i2c_done outside WAIT SHALL be ignored.
REQ-029 restart SHALL be accepted in any state: it clears init_done/init_err and goes to PWRW next cycle. While in WAIT it SHALL abort the transfer, and a later stray i2c_done SHALL be ignored.
REQ-030 If restart and i2c_done coincide, restart SHALL win.
REQ-031 At most one i2c_exec SHALL be outstanding at any time.
REQ-032 Counters SHALL saturate, never wrap; the delay counter SHALL be 26 bits or wider.

Reset
REQ-033 On rst=1, i2c_exec, i2c_addr, i2c_data, cfg_idx, init_done and init_err SHALL all be 0, and the state SHALL be PWRW with counters 0.
REQ-034 rst asserted mid-transfer SHALL behave as restart, and the mid-transfer i2c_done SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold the cmd encodings, the entry width (26), the FSM state encoding and the entry field-slice constants.
REQ-036 One sub-module, i2c_sensor_cfg_rom, SHALL map a 10-bit index to a 26-bit entry with a 1-cycle registered read, and is sensor-specific.
REQ-037 Indices not present in the ROM SHALL return END.

Verification
REQ-038 REG_NUM=4, ROM {WR 12/80, DLY 1, WR 3d/03, END}, DLY_UNIT=10, ACK on every transfer: expect exactly 2 exec pulses, 10 idle cycles between done#1 and exec#2, and init_done=1.
REQ-039 NACK the first 2 attempts of entry 0 with MAX_RETRY=3: expect 3 exec pulses with identical addr/data, then progression to entry 1.
REQ-040 NACK 4 times on entry 2: expect init_err=1, cfg_idx=2, init_done=0, and no further exec.
REQ-041 ADDR16=1 with entry WR 3008/82: expect i2c_addr=16'h3008 and i2c_bit_ctrl=1.
REQ-042 Assert restart while in WAIT, then pulse i2c_done: expect the pulse ignored, PWR_WAIT idle cycles, and exec re-issued for entry 0.
REQ-043 Assert rst after init_done: expect all outputs 0 and the sequence re-run from entry 0 after PWR_WAIT.

Source files
------------

// File: rtl/i2c_sensor_seq_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sensor_seq_cfg_pkg
// Description : Shared types and constants for the I2C sensor configuration
//               sequencer: table entry layout, command codes, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_sensor_seq_cfg_pkg;

    localparam int c_ENTRY_W  = 26;
    localparam int c_CMD_MSB  = 25;
    localparam int c_CMD_LSB  = 24;
    localparam int c_ADDR_MSB = 23;
    localparam int c_ADDR_LSB = 8;
    localparam int c_DATA_MSB = 7;
    localparam int c_DATA_LSB = 0;

    typedef enum logic [1:0] {
        CMD_WR  = 2'd0,
        CMD_DLY = 2'd1,
        CMD_END = 2'd2
    } cfg_cmd_t;

    typedef enum logic [2:0] {
        S_PWRW  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DELAY = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } seq_state_t;

    function automatic logic [c_ENTRY_W-1:0] mk_entry(input cfg_cmd_t cmd,
                                                      input logic [15:0] addr,
                                                      input logic [7:0] data);
        return {cmd, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_sensor_cfg_rom.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sensor_cfg_rom
// Description : Sensor-specific configuration table, 10-bit index to 26-bit
//               entry, one-cycle registered read. Unlisted indices read END.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sensor_cfg_rom
    import i2c_sensor_seq_cfg_pkg::*;
#(
    parameter int ADDR16 = 0
) (
    input  logic                 clk,
    input  logic [9:0]           i_idx,
    output logic [c_ENTRY_W-1:0] o_entry
);

    logic [c_ENTRY_W-1:0] w_entry;

    always_comb begin
        w_entry = mk_entry(CMD_END, 16'h0000, 8'h00);
        case (i_idx)
            10'd0: w_entry = (ADDR16 != 0) ? mk_entry(CMD_WR, 16'h3008, 8'h82)
                                            : mk_entry(CMD_WR, 16'h0012, 8'h80);
            10'd1: w_entry = mk_entry(CMD_DLY, 16'h0000, 8'h01);
            10'd2: w_entry = (ADDR16 != 0) ? mk_entry(CMD_WR, 16'h3103, 8'h03)
                                            : mk_entry(CMD_WR, 16'h003d, 8'h03);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        o_entry <= w_entry;
    end

endmodule
`default_nettype wire

// File: rtl/i2c_sensor_seq_cfg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sensor_seq_cfg
// Description : Walks the sensor configuration table after power-up, issuing
//               I2C writes and delays with NACK retry, then flags done/error.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sensor_seq_cfg
    import i2c_sensor_seq_cfg_pkg::*;
#(
    parameter int REG_NUM   = 70,
    parameter int ADDR16    = 0,
    parameter int PWR_WAIT  = 1023,
    parameter int DLY_UNIT  = 1000,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        i2c_exec,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data,
    output logic        i2c_bit_ctrl,
    output logic [9:0]  cfg_idx,
    output logic        init_done,
    output logic        init_err
);

    localparam logic [31:0] c_PWR_LAST  = (PWR_WAIT > 0) ? 32'(PWR_WAIT - 1) : 32'd0;
    localparam logic [9:0]  c_REG_NUM   = 10'(REG_NUM);
    localparam logic [7:0]  c_MAX_RETRY = 8'(MAX_RETRY);
    localparam logic [9:0]  c_IDX_MAX   = 10'h3FF;

    seq_state_t           r_state, w_state_nxt;
    logic [9:0]           r_idx, w_idx_nxt, w_idx_inc;
    logic [31:0]          r_cnt, w_cnt_nxt, w_cnt_inc, w_dly_cycles;
    logic [7:0]           r_retry, w_retry_nxt;
    logic [15:0]          r_addr, w_addr_nxt, w_rom_addr;
    logic [7:0]           r_data, w_data_nxt, w_rom_data;
    logic [c_ENTRY_W-1:0] w_rom_entry;
    cfg_cmd_t             w_cmd;

    // Addressed with the next index so the entry is ready in the FETCH cycle.
    i2c_sensor_cfg_rom #(
        .ADDR16 (ADDR16)
    ) u_rom (
        .clk     (clk),
        .i_idx   (w_idx_nxt),
        .o_entry (w_rom_entry)
    );

    assign w_cmd        = cfg_cmd_t'(w_rom_entry[c_CMD_MSB:c_CMD_LSB]);
    assign w_rom_addr   = (ADDR16 != 0) ? w_rom_entry[c_ADDR_MSB:c_ADDR_LSB]
                                        : {8'h00, w_rom_entry[c_ADDR_LSB+7:c_ADDR_LSB]};
    assign w_rom_data   = w_rom_entry[c_DATA_MSB:c_DATA_LSB];
    assign w_dly_cycles = 32'(w_rom_data) * 32'(DLY_UNIT);
    assign w_idx_inc    = (r_idx == c_IDX_MAX) ? r_idx : r_idx + 10'd1;
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        case (r_state)
            S_PWRW: begin
                if (r_cnt >= c_PWR_LAST) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = 10'd0;
                    w_cnt_nxt   = 32'd0;
                    w_retry_nxt = 8'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_FETCH: begin
                if (r_idx >= c_REG_NUM) begin
                    w_state_nxt = S_DONE;
                end else begin
                    case (w_cmd)
                        CMD_WR: begin
                            w_state_nxt = S_ISSUE;
                            w_addr_nxt  = w_rom_addr;
                            w_data_nxt  = w_rom_data;
                        end
                        CMD_DLY: begin
                            // A zero-length delay skips straight to the next entry.
                            if (w_dly_cycles == 32'd0) begin
                                w_idx_nxt = w_idx_inc;
                            end else begin
                                w_state_nxt = S_DELAY;
                                w_cnt_nxt   = w_dly_cycles - 32'd1;
                            end
                        end
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = w_idx_inc;
                        w_retry_nxt = 8'd0;
                    end else if (r_retry < c_MAX_RETRY) begin
                        w_state_nxt = S_ISSUE;
                        w_retry_nxt = r_retry + 8'd1;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt == 32'd0) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = w_idx_inc;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            S_DONE, S_ERR: ;
            default: w_state_nxt = S_PWRW;
        endcase
        // Restart overrides everything, including a coincident i2c_done.
        if (restart) begin
            w_state_nxt = S_PWRW;
            w_idx_nxt   = 10'd0;
            w_cnt_nxt   = 32'd0;
            w_retry_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PWRW;
            r_idx   <= 10'd0;
            r_cnt   <= 32'd0;
            r_retry <= 8'd0;
            r_addr  <= 16'd0;
            r_data  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign i2c_exec     = (r_state == S_ISSUE);
    assign i2c_addr     = r_addr;
    assign i2c_data     = r_data;
    assign i2c_bit_ctrl = (ADDR16 != 0);
    assign cfg_idx      = r_idx;
    assign init_done    = (r_state == S_DONE);
    assign init_err     = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_i2c_sensor_seq_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_sensor_seq_cfg
// Description : Directed self-checking bench for i2c_sensor_seq_cfg with an
//               8-bit and a 16-bit address instance driven in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_sensor_seq_cfg;

    localparam int PW = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;

    logic        exec_a, bit_a, done_a, err_a;
    logic [15:0] addr_a;
    logic [7:0]  data_a;
    logic [9:0]  idx_a;
    logic        exec_b, bit_b, done_b, err_b;
    logic [15:0] addr_b;
    logic [7:0]  data_b;
    logic [9:0]  idx_b;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_exec = 0;

    i2c_sensor_seq_cfg #(
        .REG_NUM(4), .ADDR16(0), .PWR_WAIT(PW), .DLY_UNIT(10), .MAX_RETRY(3)
    ) u_dut (
        .clk(clk), .rst(rst), .restart(restart), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .i2c_exec(exec_a), .i2c_addr(addr_a), .i2c_data(data_a), .i2c_bit_ctrl(bit_a),
        .cfg_idx(idx_a), .init_done(done_a), .init_err(err_a)
    );

    i2c_sensor_seq_cfg #(
        .REG_NUM(4), .ADDR16(1), .PWR_WAIT(PW), .DLY_UNIT(10), .MAX_RETRY(3)
    ) u_dut16 (
        .clk(clk), .rst(rst), .restart(restart), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .i2c_exec(exec_b), .i2c_addr(addr_b), .i2c_data(data_b), .i2c_bit_ctrl(bit_b),
        .cfg_idx(idx_b), .init_done(done_b), .init_err(err_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) if (exec_a === 1'b1) n_exec <= n_exec + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_exec(input int max_cyc, output int n);
        n = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (exec_a === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse_done(input logic nack);
        i2c_done = 1'b1;
        i2c_nack = nack;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
    endtask

    initial begin
        int n;
        int e0;
        repeat (3) tick();
        chk("rst_exec", 32'(exec_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_idx",  32'(idx_a),  32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err",  32'(err_a),  32'd0);
        chk("bitctrl8",  32'(bit_a), 32'd0);
        chk("bitctrl16", 32'(bit_b), 32'd1);
        rst = 1'b0;

        // Power-up wait of PW cycles plus one FETCH cycle before the first exec.
        wait_exec(100, n);
        chk("pwr_lat", 32'(n), 32'(PW + 1));
        chk("e0_addr", 32'(addr_a), 32'h0012);
        chk("e0_data", 32'(data_a), 32'h80);
        chk("a16_addr", 32'(addr_b), 32'h3008);
        chk("a16_data", 32'(data_b), 32'h82);
        tick();
        chk("exec_1cyc", 32'(exec_a), 32'd0);

        // Two NACKs on entry 0 -> two immediate re-issues with same payload.
        pulse_done(1'b1);
        chk("retry1_exec", 32'(exec_a), 32'd1);
        chk("retry1_addr", 32'(addr_a), 32'h0012);
        tick();
        pulse_done(1'b1);
        chk("retry2_exec", 32'(exec_a), 32'd1);
        chk("retry2_data", 32'(data_a), 32'h80);
        tick();
        pulse_done(1'b0);
        chk("adv_idx1", 32'(idx_a), 32'd1);
        chk("exec_cnt3", 32'(n_exec), 32'd3);

        // FETCH(delay entry) + 10 delay cycles + FETCH(entry 2) -> exec on 12th.
        wait_exec(50, n);
        chk("dly_gap", 32'(n), 32'd12);
        chk("e2_addr", 32'(addr_a), 32'h003d);
        chk("e2_idx",  32'(idx_a),  32'd2);

        // Entry 2: retry count was cleared, so 4 NACKs are needed to fail.
        for (int r = 0; r < 3; r++) begin
            tick();
            pulse_done(1'b1);
            chk("e2_retry_exec", 32'(exec_a), 32'd1);
        end
        tick();
        pulse_done(1'b1);
        chk("err_flag", 32'(err_a), 32'd1);
        chk("err_idx",  32'(idx_a), 32'd2);
        chk("err_done", 32'(done_a), 32'd0);
        pulse_done(1'b0);
        repeat (30) tick();
        chk("err_hold", 32'(err_a), 32'd1);
        chk("err_noexec", 32'(n_exec), 32'd7);

        // Restart from ERR, then an all-ACK pass through the table.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_err_clr", 32'(err_a), 32'd0);
        e0 = n_exec;
        wait_exec(100, n);
        chk("rs_lat", 32'(n), 32'(PW + 1));
        tick();
        pulse_done(1'b0);
        wait_exec(50, n);
        chk("ack_dly_gap", 32'(n), 32'd12);
        tick();
        pulse_done(1'b0);
        tick();
        chk("ack_done", 32'(done_a), 32'd1);
        chk("ack_idx",  32'(idx_a),  32'd3);
        chk("ack_err",  32'(err_a),  32'd0);
        repeat (5) tick();
        chk("ack_2exec", 32'(n_exec - e0), 32'd2);

        // Restart while WAITing, coincident with i2c_done, then a stray done.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_done_clr", 32'(done_a), 32'd0);
        wait_exec(100, n);
        chk("rs2_lat", 32'(n), 32'(PW + 1));
        tick();
        restart  = 1'b1;
        i2c_done = 1'b1;
        tick();
        restart  = 1'b0;
        i2c_done = 1'b0;
        chk("rs_wins_idx", 32'(idx_a), 32'd0);
        pulse_done(1'b0);
        chk("stray_idx", 32'(idx_a), 32'd0);
        wait_exec(100, n);
        chk("stray_lat", 32'(n), 32'(PW));
        chk("stray_addr", 32'(addr_a), 32'h0012);

        // Complete, then reset after init_done.
        tick();
        pulse_done(1'b0);
        wait_exec(50, n);
        tick();
        pulse_done(1'b0);
        tick();
        chk("run2_done", 32'(done_a), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        chk("rst2_exec", 32'(exec_a), 32'd0);
        chk("rst2_addr", 32'(addr_a), 32'd0);
        chk("rst2_data", 32'(data_a), 32'd0);
        chk("rst2_idx",  32'(idx_a),  32'd0);
        chk("rst2_done", 32'(done_a), 32'd0);
        chk("rst2_err",  32'(err_a),  32'd0);
        rst = 1'b0;
        wait_exec(100, n);
        chk("rst2_lat",  32'(n), 32'(PW + 1));
        chk("rst2_e0",   32'(addr_a), 32'h0012);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
